// File: rtl/eq_pkg.sv
// -----------------------------------------------------------------------------
// eq_pkg
// Shared definitions for the nibble-equality BIST stimulus blocks.
//   state_e     : control FSM states of eq_pattern_gen (IDLE, RUN, DONE)
//   LFSR_W      : width of the filler LFSR
//   LFSR_TAPS   : Fibonacci tap mask (taps 8,6,5,4 -> bits 7,5,4,3)
//   is_eq_half  : true when a 4-bit word has its high half equal to its low half
// No ports (package).
// -----------------------------------------------------------------------------
package eq_pkg;

    localparam int LFSR_W = 8;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic is_eq_half(input logic [3:0] w);
        return (w[3:2] == w[1:0]);
    endfunction

endpackage

// File: rtl/eq_lfsr8.sv
// -----------------------------------------------------------------------------
// eq_lfsr8
// 8-bit Fibonacci LFSR used as pseudo-random filler by BIST stimulus blocks.
// Shifts left, XOR of the tapped bits enters at bit 0.
// Parameters:
//   SEED       reset value; an all-zero seed would lock up, so it becomes 8'h01
// Ports:
//   clk_i      input   clock, rising edge
//   rst_ni     input   synchronous active-low reset (reloads SEED)
//   advance_i  input   step the register one position this cycle
//   state_o    output  current 8-bit LFSR state
// -----------------------------------------------------------------------------
module eq_lfsr8
    import eq_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              advance_i,
    output logic [LFSR_W-1:0] state_o
);

    localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? 8'h01 : SEED;

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (advance_i) begin
            lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            lfsr_q <= SEED_EFF;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/eq_pattern_gen.sv
// -----------------------------------------------------------------------------
// eq_pattern_gen
// Emits a run of total_len_i 4-bit words, one per transfer, of which exactly
// target_i have high half == low half. Filler comes from an internal LFSR that
// persists across runs and is reseeded only by reset.
// Optional feature (macro EQ_PATTERN_GEN_READY_EN): adds ready_i; a word
// transfers only when valid_o && ready_i, otherwise everything holds.
// Parameters:
//   CNT_W        width of target / length / sent counters
//   LFSR_SEED    LFSR reset value (0 is replaced by 8'h01)
// Ports:
//   clk_i        input   clock, rising edge
//   rst_ni       input   synchronous active-low reset
//   start_i      input   request a run (sampled only in IDLE)
//   target_i     input   number of equal-half words to emit
//   total_len_i  input   total words in the run
//   ready_i      input   downstream ready (only with EQ_PATTERN_GEN_READY_EN)
//   word_o       output  emitted word (holds when valid_o is low)
//   valid_o      output  word_o is a stream word this cycle
//   busy_o       output  high in RUN and DONE
//   done_o       output  one-cycle pulse at end of run
//   err_o        output  target_i > total_len_i at start; held until next start
//   eq_sent_o    output  equal-half words emitted this run
// -----------------------------------------------------------------------------
module eq_pattern_gen
    import eq_pkg::*;
#(
    parameter int                CNT_W     = 8,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 8'hA5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [CNT_W-1:0] target_i,
    input  logic [CNT_W-1:0] total_len_i,
`ifdef EQ_PATTERN_GEN_READY_EN
    input  logic             ready_i,
`endif
    output logic [3:0]       word_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [CNT_W-1:0] eq_sent_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  rem_words_q, rem_words_d;
    logic [CNT_W-1:0]  rem_eq_q, rem_eq_d;
    logic [CNT_W-1:0]  eq_sent_q, eq_sent_d;
    logic              err_q, err_d;
    logic [3:0]        word_q, word_d;

    logic [LFSR_W-1:0] lfsr_state;
    logic              lfsr_adv;
    logic [3:0]        raw;
    logic [3:0]        word_run;
    logic              xfer;
    logic              unused_lfsr_hi;

    eq_lfsr8 #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .advance_i(lfsr_adv),
        .state_o  (lfsr_state)
    );

    assign raw            = lfsr_state[3:0];
    assign unused_lfsr_hi = ^lfsr_state[LFSR_W-1:4];

`ifdef EQ_PATTERN_GEN_READY_EN
    assign xfer = (state_q == RUN) && ready_i;
`else
    assign xfer = (state_q == RUN);
`endif

    // Shape the raw nibble: once the remaining equal quota fills every remaining
    // slot it must be equal; once the quota is exhausted a chance-equal nibble
    // is broken by flipping the low bit of its high half.
    always_comb begin
        word_run = raw;
        if (rem_eq_q == rem_words_q) begin
            word_run = {raw[1:0], raw[1:0]};
        end else if ((rem_eq_q == '0) && is_eq_half(raw)) begin
            word_run = {raw[1:0] ^ 2'b01, raw[1:0]};
        end
    end

    always_comb begin
        state_d     = state_q;
        rem_words_d = rem_words_q;
        rem_eq_d    = rem_eq_q;
        eq_sent_d   = eq_sent_q;
        err_d       = err_q;
        word_d      = word_q;
        lfsr_adv    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    rem_words_d = total_len_i;
                    rem_eq_d    = target_i;
                    eq_sent_d   = '0;
                    err_d       = 1'b0;
                    if (target_i > total_len_i) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else if (total_len_i == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (xfer) begin
                    lfsr_adv    = 1'b1;
                    word_d      = word_run;
                    rem_words_d = rem_words_q - CNT_ONE;
                    if (is_eq_half(word_run)) begin
                        rem_eq_d  = rem_eq_q - CNT_ONE;
                        eq_sent_d = eq_sent_q + CNT_ONE;
                    end
                    if (rem_words_q == CNT_ONE) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            rem_words_q <= '0;
            rem_eq_q    <= '0;
            eq_sent_q   <= '0;
            err_q       <= 1'b0;
            word_q      <= '0;
        end else begin
            state_q     <= state_d;
            rem_words_q <= rem_words_d;
            rem_eq_q    <= rem_eq_d;
            eq_sent_q   <= eq_sent_d;
            err_q       <= err_d;
            word_q      <= word_d;
        end
    end

    // In RUN the live word is shown; word_q keeps the last transferred word
    // so word_o holds once valid_o drops.
    assign valid_o   = (state_q == RUN);
    assign word_o    = valid_o ? word_run : word_q;
    assign busy_o    = (state_q != IDLE);
    assign done_o    = (state_q == DONE);
    assign err_o     = err_q;
    assign eq_sent_o = eq_sent_q;

endmodule

// File: tb/tb_eq_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_eq_pattern_gen
// Self-checking bench for eq_pattern_gen. A reference model of the spec'd
// stream pushes every expected word into a queue when a run is started; words
// are popped and compared as the DUT transfers them. Observed words are also
// fed to an equality counter whose total must equal the programmed target.
// -----------------------------------------------------------------------------
module tb_eq_pattern_gen;

    localparam int CNT_W = 8;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             start_i;
    logic [CNT_W-1:0] target_i;
    logic [CNT_W-1:0] total_len_i;
`ifdef EQ_PATTERN_GEN_READY_EN
    logic             ready_i;
`endif
    logic [3:0]       word_o;
    logic             valid_o;
    logic             busy_o;
    logic             done_o;
    logic             err_o;
    logic [CNT_W-1:0] eq_sent_o;

    always #5 clk_i = ~clk_i;

    eq_pattern_gen #(
        .CNT_W    (CNT_W),
        .LFSR_SEED(8'hA5)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (start_i),
        .target_i   (target_i),
        .total_len_i(total_len_i),
`ifdef EQ_PATTERN_GEN_READY_EN
        .ready_i    (ready_i),
`endif
        .word_o     (word_o),
        .valid_o    (valid_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .eq_sent_o  (eq_sent_o)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    logic [3:0] exp_q[$];
    logic [7:0] m_lfsr;
    logic [3:0] last_word;
    logic [3:0] run_first;
    logic [3:0] pu_first;
    logic       rdy;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model of one emitted word; advances the model LFSR.
    task automatic model_word(input logic [7:0] rw, input logic [7:0] re, output logic [3:0] w);
        logic [3:0] r;
        r = m_lfsr[3:0];
        if (re == rw)
            w = {r[1:0], r[1:0]};
        else if (re == 8'd0 && r[3:2] == r[1:0])
            w = {r[1:0] ^ 2'b01, r[1:0]};
        else
            w = r;
        m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    endtask

    task automatic run_case(input logic [7:0] tgt, input logic [7:0] len, input int abort_at);
        logic [7:0] rw, re;
        logic [3:0] w;
        logic [3:0] held;
        bit         exp_err, done_seen, first, stalled;
        int         n_valid, n_eq, cycles, limit;

        exp_q.delete();
        exp_err = (tgt > len);
        if (!exp_err) begin
            rw = len;
            re = tgt;
            for (int i = 0; i < int'(len); i++) begin
                model_word(rw, re, w);
                exp_q.push_back(w);
                if (w[3:2] == w[1:0]) re = re - 8'd1;
                rw = rw - 8'd1;
            end
        end

        @(negedge clk_i);
        start_i     = 1'b1;
        target_i    = tgt;
        total_len_i = len;
        @(negedge clk_i);
        start_i     = 1'b0;
        target_i    = 8'($urandom);
        total_len_i = 8'($urandom);

        check("first_valid", 32'(valid_o), 32'(!exp_err && len != 8'd0));

        n_valid   = 0;
        n_eq      = 0;
        cycles    = 0;
        done_seen = 1'b0;
        first     = 1'b1;
        stalled   = 1'b0;
        held      = '0;
        limit     = 8 * int'(len) + 20;

        while (!done_seen && cycles < limit) begin
`ifdef EQ_PATTERN_GEN_READY_EN
            rdy     = 1'($urandom_range(0, 1));
            ready_i = rdy;
`else
            rdy = 1'b1;
`endif
            if (valid_o) begin
                if (stalled) check("stall_hold", 32'(word_o), 32'(held));
                if (exp_q.size() == 0) begin
                    check("extra_word", 32'(1), 32'(0));
                end else begin
                    check("word", 32'(word_o), 32'(exp_q[0]));
                    if (rdy) void'(exp_q.pop_front());
                end
                if (first) begin
                    run_first = word_o;
                    first     = 1'b0;
                end
                stalled = !rdy;
                held    = word_o;
                if (rdy) begin
                    n_valid++;
                    if (word_o[3:2] == word_o[1:0]) n_eq++;
                    last_word = word_o;
                end
            end
            if (done_o) begin
                done_seen = 1'b1;
                check("eq_sent", 32'(eq_sent_o), exp_err ? 32'(0) : 32'(tgt));
                check("err", 32'(err_o), 32'(exp_err));
                check("valid_count", 32'(n_valid), exp_err ? 32'(0) : 32'(len));
                check("eq_counter", 32'(n_eq), exp_err ? 32'(0) : 32'(tgt));
                check("queue_empty", 32'(exp_q.size()), 32'(0));
                check("word_hold", 32'(word_o), 32'(last_word));
                check("done_valid", 32'(valid_o), 32'(0));
`ifndef EQ_PATTERN_GEN_READY_EN
                check("done_cycle", 32'(cycles), (exp_err || len == 8'd0) ? 32'(0) : 32'(len));
`endif
            end else if (abort_at > 0 && n_valid == abort_at) begin
                rst_ni = 1'b0;
                @(negedge clk_i);
                check("rst_valid", 32'(valid_o), 32'(0));
                check("rst_busy", 32'(busy_o), 32'(0));
                check("rst_done", 32'(done_o), 32'(0));
                check("rst_word", 32'(word_o), 32'(0));
                check("rst_eq_sent", 32'(eq_sent_o), 32'(0));
                rst_ni = 1'b1;
                @(negedge clk_i);
                check("rst_no_done", 32'(done_o), 32'(0));
                m_lfsr    = 8'hA5;
                last_word = '0;
                exp_q.delete();
`ifdef EQ_PATTERN_GEN_READY_EN
                ready_i = 1'b1;
`endif
                return;
            end else begin
                @(negedge clk_i);
                cycles++;
            end
        end

        if (!done_seen) begin
            check("done_timeout", 32'(0), 32'(1));
        end else begin
            @(negedge clk_i);
            check("done_pulse", 32'(done_o), 32'(0));
            check("idle_busy", 32'(busy_o), 32'(0));
        end
    endtask

    initial begin
        rst_ni      = 1'b0;
        start_i     = 1'b0;
        target_i    = '0;
        total_len_i = '0;
        rdy         = 1'b1;
        last_word   = '0;
        run_first   = '0;
        pu_first    = '0;
        m_lfsr      = 8'hA5;
`ifdef EQ_PATTERN_GEN_READY_EN
        ready_i     = 1'b1;
`endif
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("reset_valid", 32'(valid_o), 32'(0));
        check("reset_busy", 32'(busy_o), 32'(0));
        check("reset_done", 32'(done_o), 32'(0));
        check("reset_err", 32'(err_o), 32'(0));
        check("reset_word", 32'(word_o), 32'(0));
        check("reset_eq_sent", 32'(eq_sent_o), 32'(0));

        run_case(8'd3, 8'd10, 0);
        pu_first = run_first;
        run_case(8'd5, 8'd5, 0);
        run_case(8'd0, 8'd6, 0);
        run_case(8'd9, 8'd4, 0);
        run_case(8'd0, 8'd0, 0);
        run_case(8'd7, 8'd40, 0);
        run_case(8'd3, 8'd20, 4);
        run_case(8'd3, 8'd10, 0);
        check("reseed_first", 32'(run_first), 32'(pu_first));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
